// File: rtl/baopoco_status_arbiter.sv
// rtl/baopoco_status_arbiter.sv - OPB status window with round-robin capture of C_NUM_SRC producers
// Shadow words can be frozen by the PPC so a multi-word read is coherent.
module baopoco_status_arbiter #(
  parameter logic [31:0] C_BASEADDR   = 32'h0108D900,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108D9FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_SRC    = 4,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  input  logic [32*C_NUM_SRC-1:0]   src_data,
  input  logic [C_NUM_SRC-1:0]      src_valid,
  output logic [C_NUM_SRC-1:0]      src_ack
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  localparam bit unused_family = (C_FAMILY == "virtex5");

  state_t      state, state_nxt;
  logic [31:0] abus, offset, wdata, rd_word, rd_data, ctrl_word;
  logic [29:0] word_idx;
  logic        hit, start;
  logic        freeze;
  logic [15:0] count;
  logic [3:0]  last_grant;
  logic [31:0] shadow [C_NUM_SRC];
  logic        grant_any, capture;
  int          grant_sel, cand;
  logic        unused_bits;

  assign abus     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign offset   = abus - C_BASEADDR;
  assign word_idx = offset[31:2];
  assign hit      = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign start    = (state == IDLE) && hit;

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign Sl_xferAck = (state == ACK);
  assign Sl_DBus    = rd_data;

  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:1], offset[1:0], unused_family};

  assign ctrl_word = {count, 8'h00, last_grant, 3'b000, freeze};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ACK;
      ACK:     state_nxt = OPB_select ? WAIT : IDLE;
      WAIT:    if (!OPB_select) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (word_idx == 30'd0) rd_word = ctrl_word;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (word_idx == 30'(i + 1)) rd_word = shadow[i];
    end
  end

  // Round-robin search starts just after the last source captured.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 0;
    cand      = 0;
    for (int k = 1; k <= C_NUM_SRC; k++) begin
      cand = (int'(last_grant) + k) % C_NUM_SRC;
      if (!grant_any && src_valid[cand]) begin
        grant_any = 1'b1;
        grant_sel = cand;
      end
    end
  end

  assign capture = grant_any && !freeze && !OPB_Rst;

  always_comb begin
    src_ack = '0;
    if (capture) src_ack[grant_sel] = 1'b1;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= IDLE;
      rd_data    <= '0;
      freeze     <= 1'b0;
      count      <= '0;
      last_grant <= 4'(C_NUM_SRC - 1);
      for (int i = 0; i < C_NUM_SRC; i++) shadow[i] <= '0;
    end else begin
      state   <= state_nxt;
      rd_data <= '0;
      // Read data is taken before this edge's capture lands.
      if (start && OPB_RNW) rd_data <= rd_word;
      if (start && !OPB_RNW && word_idx == 30'd0 && OPB_BE[3]) freeze <= wdata[0];
      if (capture) begin
        shadow[grant_sel] <= src_data[32*grant_sel +: 32];
        last_grant        <= 4'(grant_sel);
        count             <= count + 16'd1;
      end
    end
  end

endmodule
